// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALUOp and mux-select constants, and the control bundle driven to the datapath.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Shared with alu_control.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle: opcode and memory handshake in, control strobes out.
interface multicycle_control_if;

   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic [3:0] state;
   logic       illegal;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state, illegal
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state, illegal
   );

endinterface

// File: rtl/mc_output_decode.sv
// Moore control decode from the FSM state; only the FETCH write enables look at
// mem_ready so IR and PC load exactly once per completed instruction fetch.
module mc_output_decode
   import mips_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves a
      // control unassigned, which would otherwise infer a latch.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_WB: ctrl.reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, next-state
// logic, and reset gating of the decoded control bundle.
module multicycle_control
   import mips_pkg::*;
(
   input logic                  clk,
   input logic                  rstn,
   multicycle_control_if.master bus
);

   state_e state_q, state_d;
   ctrl_t  ctrl_raw, ctrl;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR: begin
            if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
            else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
            else                          state_d = S_FETCH;
         end
         S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH  : S_MEM_WRITE;
         S_EXECUTE:   state_d = S_R_WB;
         S_ADDI_EX:   state_d = S_ADDI_WB;
         default:     state_d = S_FETCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   mc_output_decode u_output_decode (
      .state     (state_q),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl_raw)
   );

   // Gating with rstn kills any write enable the instant reset asserts,
   // without waiting for the state register to settle.
   assign ctrl = rstn ? ctrl_raw : '0;

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.i_or_d        = ctrl.i_or_d;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.state         = state_q;
   assign bus.illegal       = rstn && (state_q == S_DECODE) && !is_legal_op(bus.opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the expected
// state/controls, a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
   import mips_pkg::*;

   typedef struct {
      logic [3:0]  st;
      logic [15:0] ctrl;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bit order: pw pwc iod mrd mwr irw m2r rdst rwr srca srcb[2] aluop[2] pcsrc[2]
   function automatic logic [15:0] obs_ctrl();
      return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
              bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
              bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source};
   endfunction

   function automatic logic [15:0] exp_ctrl(input state_e s, input logic mr);
      logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
      logic rdst = 0, rwr = 0, srca = 0;
      logic [1:0] srcb = 2'b00, aop = 2'b00, pcs = 2'b00;
      case (s)
         S_FETCH:     begin mrd = 1; srcb = 2'b01; irw = mr; pw = mr; end
         S_DECODE:    srcb = 2'b11;
         S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
         S_ADDI_EX:   begin srca = 1; srcb = 2'b10; end
         S_MEM_READ:  begin mrd = 1; iod = 1; end
         S_MEM_WRITE: begin mwr = 1; iod = 1; end
         S_MEM_WB:    begin rwr = 1; m2r = 1; end
         S_EXECUTE:   begin srca = 1; aop = 2'b10; end
         S_R_WB:      begin rwr = 1; rdst = 1; end
         S_BRANCH:    begin srca = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
         S_JUMP:      begin pw = 1; pcs = 2'b10; end
         S_ADDI_WB:   rwr = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, pcs};
   endfunction

   function automatic logic supported(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   function automatic logic [5:0] junk_op();
      return 6'($urandom);
   endfunction

   function automatic logic junk_bit();
      return 1'($urandom);
   endfunction

   // One clock cycle: drive inputs just after the edge and queue the expectation.
   task automatic step(input state_e s, input logic [5:0] op, input logic mr, input bit in_rst);
      exp_t e;
      @(posedge clk);
      #1;
      rstn          = !in_rst;
      bus.opcode    = op;
      bus.mem_ready = mr;
      if (in_rst) begin
         e.st = 4'd0; e.ctrl = '0; e.ill = 1'b0;
      end else begin
         e.st   = s;
         e.ctrl = exp_ctrl(s, mr);
         e.ill  = (s == S_DECODE) && !supported(op);
      end
      sb_q.push_back(e);
   endtask

   task automatic run(input logic [5:0] op, input int fetch_waits, input int mem_waits);
      for (int i = 0; i < fetch_waits; i++) step(S_FETCH, junk_op(), 1'b0, 0);
      step(S_FETCH, junk_op(), 1'b1, 0);
      step(S_DECODE, op, junk_bit(), 0);
      case (op)
         OP_LW: begin
            step(S_MEM_ADDR, op, junk_bit(), 0);
            for (int i = 0; i < mem_waits; i++) step(S_MEM_READ, junk_op(), 1'b0, 0);
            step(S_MEM_READ, junk_op(), 1'b1, 0);
            step(S_MEM_WB, junk_op(), junk_bit(), 0);
         end
         OP_SW: begin
            step(S_MEM_ADDR, op, junk_bit(), 0);
            for (int i = 0; i < mem_waits; i++) step(S_MEM_WRITE, junk_op(), 1'b0, 0);
            step(S_MEM_WRITE, junk_op(), 1'b1, 0);
         end
         OP_RTYPE: begin
            step(S_EXECUTE, junk_op(), junk_bit(), 0);
            step(S_R_WB, junk_op(), junk_bit(), 0);
         end
         OP_ADDI: begin
            step(S_ADDI_EX, junk_op(), junk_bit(), 0);
            step(S_ADDI_WB, junk_op(), junk_bit(), 0);
         end
         OP_BEQ: step(S_BRANCH, junk_op(), junk_bit(), 0);
         OP_J:   step(S_JUMP, junk_op(), junk_bit(), 0);
         default: ;
      endcase
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("state", 32'(bus.state), 32'(e.st));
            check("ctrl", 32'(obs_ctrl()), 32'(e.ctrl));
            check("illegal", 32'(bus.illegal), 32'(e.ill));
         end
      end
   end

   initial begin : stimulus
      bus.opcode    = 6'b0;
      bus.mem_ready = 1'b1;
      step(S_FETCH, junk_op(), 1'b1, 1);
      step(S_FETCH, junk_op(), 1'b1, 1);

      run(OP_LW, 0, 0);
      run(OP_SW, 0, 2);
      run(OP_RTYPE, 0, 0);
      run(OP_ADDI, 0, 0);
      run(OP_BEQ, 0, 0);
      run(OP_J, 0, 0);
      run(OP_LW, 3, 1);
      run(6'b111111, 0, 0);
      run(6'b010101, 1, 0);

      // lw stalled in MEM_READ, then reset dropped between clock edges.
      step(S_FETCH, junk_op(), 1'b1, 0);
      step(S_DECODE, OP_LW, 1'b1, 0);
      step(S_MEM_ADDR, OP_LW, 1'b1, 0);
      step(S_MEM_READ, junk_op(), 1'b0, 0);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_state", 32'(bus.state), 32'(S_FETCH));
      check("async_rst_ctrl", 32'(obs_ctrl()), 32'h0);
      step(S_FETCH, junk_op(), 1'b1, 1);
      run(OP_RTYPE, 0, 0);
      run(OP_SW, 0, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
